// File: rtl/distance_filter_pkg.sv
// Shared elevator distance-filter constants, sample classification type and
// the distance comparison helper used by the reject logic.
package distance_filter_pkg;

  localparam int DATA_W          = 16;
  localparam int REJ_CNT_W       = 8;

  localparam int DEPTH_DEF       = 4;
  localparam int MAX_CM_DEF      = 400;
  localparam int STEP_LIMIT_DEF  = 10;
  localparam int TIMEOUT_CYC_DEF = 24_000_000;
  localparam int REJ_RUN_MAX     = 3;

  typedef enum logic [1:0] {
    SMP_IDLE,
    SMP_ACCEPT,
    SMP_RANGE_REJ,
    SMP_STEP_REJ
  } smp_class_e;

  // Magnitude of a - b for unsigned distances; the 17-bit signed difference
  // always fits back into DATA_W bits once its sign is removed.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dist_avg_buf.sv
// DEPTH-entry circular sample buffer with a running sum. Exposes the
// post-update sum/fill so the owner can publish an average in the same cycle.
module dist_avg_buf
  import distance_filter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              flush,
  input  logic                              load_first,
  input  logic [DATA_W-1:0]                 din,
  output logic [$clog2(DEPTH):0]            fill,
  output logic [$clog2(DEPTH):0]            fill_nxt,
  output logic [DATA_W+$clog2(DEPTH)-1:0]   sum_nxt
);

  localparam int LOG2_D = $clog2(DEPTH);
  localparam int SUM_W  = DATA_W + LOG2_D;
  localparam int FILL_W = LOG2_D + 1;
  localparam int PTR_W  = LOG2_D;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SUM_W-1:0]  sum_p1;
  logic [PTR_W-1:0]  ptr_p1;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [PTR_W-1:0]  wr_idx;
  logic              wr_en;

  always_comb begin
    sum_nxt  = sum_p1;
    fill_nxt = fill;
    ptr_nxt  = ptr_p1;
    wr_idx   = ptr_p1;
    wr_en    = 1'b0;
    if (load_first) begin
      sum_nxt  = SUM_W'(din);
      fill_nxt = FILL_W'(1);
      ptr_nxt  = PTR_W'(1);
      wr_idx   = '0;
      wr_en    = 1'b1;
    end else if (flush) begin
      sum_nxt  = '0;
      fill_nxt = '0;
      ptr_nxt  = '0;
    end else if (push) begin
      wr_en   = 1'b1;
      ptr_nxt = ptr_p1 + 1'b1;
      // Once full, the write slot holds the oldest sample; modular arithmetic
      // in the intermediate sum is harmless because the result always fits.
      if (fill == FILL_FULL) begin
        sum_nxt = sum_p1 + SUM_W'(din) - SUM_W'(mem[ptr_p1]);
      end else begin
        sum_nxt  = sum_p1 + SUM_W'(din);
        fill_nxt = fill + 1'b1;
      end
    end
  end

  // Stage p1: buffer contents, running sum, fill level and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      fill   <= '0;
      ptr_p1 <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      sum_p1 <= sum_nxt;
      fill   <= fill_nxt;
      ptr_p1 <= ptr_nxt;
      if (wr_en) mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/distance_filter.sv
// Ultrasonic distance conditioning: range/step rejection, moving average over
// DEPTH accepted samples, re-convergence after repeated step rejects, and a
// staleness timeout that drops the averaging history.
module distance_filter
  import distance_filter_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int MAX_CM      = MAX_CM_DEF,
  parameter int STEP_LIMIT  = STEP_LIMIT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    raw_dist,
  input  logic                 raw_valid,
  output logic [DATA_W-1:0]    filt_dist,
  output logic                 filt_valid,
  output logic                 stale,
  output logic [REJ_CNT_W-1:0] reject_cnt
);

  localparam int LOG2_D = $clog2(DEPTH);
  localparam int SUM_W  = DATA_W + LOG2_D;
  localparam int FILL_W = LOG2_D + 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [DATA_W-1:0] MAX_RAW   = DATA_W'(MAX_CM);
  localparam logic [DATA_W-1:0] STEP_MAX  = DATA_W'(STEP_LIMIT);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_PRE   = TMO_W'(TIMEOUT_CYC - 2);
  localparam logic [1:0]        RUN_FLUSH = 2'(REJ_RUN_MAX - 1);

  // Averaging by truncation: plain shift, no rounding term.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] sh;
    sh = s >> LOG2_D;
    return sh[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0]    filt_dist_p1;
  logic                 vld_p1;
  logic                 stale_p1;
  logic [REJ_CNT_W-1:0] rej_cnt_p1;
  logic [1:0]           rej_run_p1;
  logic [TMO_W-1:0]     tmo_cnt_p1;

  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_nxt;
  logic [SUM_W-1:0]     sum_nxt;

  smp_class_e           smp_class;
  logic                 primed;
  logic                 accept;
  logic                 range_rej;
  logic                 step_rej;
  logic                 flush_run;
  logic                 expire;
  logic                 publish;

  assign primed = (fill == FILL_FULL);

  always_comb begin
    smp_class = SMP_IDLE;
    if (raw_valid) begin
      if (raw_dist == '0 || raw_dist > MAX_RAW) begin
        smp_class = SMP_RANGE_REJ;
      end else if (primed && abs_diff(raw_dist, filt_dist_p1) > STEP_MAX) begin
        smp_class = SMP_STEP_REJ;
      end else begin
        smp_class = SMP_ACCEPT;
      end
    end
  end

  assign accept    = (smp_class == SMP_ACCEPT);
  assign range_rej = (smp_class == SMP_RANGE_REJ);
  assign step_rej  = (smp_class == SMP_STEP_REJ);
  // A persistent step means the floor really moved: restart from this sample.
  assign flush_run = step_rej && (rej_run_p1 == RUN_FLUSH);
  // An accepted sample on the expiry cycle keeps the history alive.
  assign expire    = !accept && (tmo_cnt_p1 == TMO_PRE);
  assign publish   = accept && (fill_nxt == FILL_FULL);

  dist_avg_buf #(
    .DEPTH(DEPTH)
  ) u_avg_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .flush      (expire),
    .load_first (flush_run),
    .din        (raw_dist),
    .fill       (fill),
    .fill_nxt   (fill_nxt),
    .sum_nxt    (sum_nxt)
  );

  // Stage p1: published average and its strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_dist_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      vld_p1 <= publish;
      if (publish) filt_dist_p1 <= avg_trunc(sum_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt_p1 <= '0;
      rej_run_p1 <= '0;
      tmo_cnt_p1 <= '0;
      stale_p1   <= 1'b0;
    end else begin
      if ((range_rej || step_rej) && rej_cnt_p1 != '1) begin
        rej_cnt_p1 <= rej_cnt_p1 + 1'b1;
      end

      if (step_rej) begin
        rej_run_p1 <= flush_run ? 2'd0 : rej_run_p1 + 2'd1;
      end else if (accept || range_rej) begin
        rej_run_p1 <= '0;
      end

      if (accept) begin
        tmo_cnt_p1 <= '0;
      end else if (tmo_cnt_p1 != TMO_LAST) begin
        tmo_cnt_p1 <= tmo_cnt_p1 + 1'b1;
      end

      if (expire) begin
        stale_p1 <= 1'b1;
      end else if (publish) begin
        stale_p1 <= 1'b0;
      end
    end
  end

  assign filt_dist  = filt_dist_p1;
  assign filt_valid = vld_p1;
  assign stale      = stale_p1;
  assign reject_cnt = rej_cnt_p1;

endmodule

// File: tb/tb_distance_filter.sv
// Scoreboard bench for distance_filter: directed samples with hand-computed
// averages queued up front, and a monitor that checks every filt_valid pulse.
module tb_distance_filter;

  logic        clk;
  logic        rst_n;
  logic [15:0] raw_dist;
  logic        raw_valid;
  logic [15:0] filt_dist;
  logic        filt_valid;
  logic        stale;
  logic [7:0]  reject_cnt;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mon_exp;

  distance_filter #(
    .DEPTH       (4),
    .MAX_CM      (400),
    .STEP_LIMIT  (10),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_dist   (raw_dist),
    .raw_valid  (raw_valid),
    .filt_dist  (filt_dist),
    .filt_valid (filt_valid),
    .stale      (stale),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && filt_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_filt_valid: got filt_dist=%0d, expected no output", filt_dist);
      end else begin
        mon_exp = exp_q.pop_front();
        if (filt_dist !== 16'(mon_exp)) begin
          errors++;
          $display("FAIL filt_dist: got %0d, expected %0d", filt_dist, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int v);
    @(negedge clk);
    raw_dist  = 16'(v);
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    raw_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b1;
    raw_valid = 1'b0;
    raw_dist  = '0;

    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_filt_dist", filt_dist, 0);
    chk("rst_filt_valid", filt_valid, 0);
    chk("rst_stale", stale, 0);
    chk("rst_reject_cnt", reject_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Priming: 20,20,24,24 -> single output of 22
    exp_q.push_back(22);
    send(20); send(20); send(24); send(24);
    idle(2);
    chk("prime_drained", exp_q.size(), 0);
    chk("prime_filt_dist", filt_dist, 22);
    chk("prime_reject_cnt", reject_cnt, 0);

    // Step reject, zero and above-range rejects
    send(60); send(0); send(401);
    idle(2);
    chk("reject_cnt_3", reject_cnt, 3);
    chk("reject_hold_filt", filt_dist, 22);
    chk("reject_drained", exp_q.size(), 0);

    // Tracking, truncation and the exact step boundary
    do_reset();
    exp_q.push_back(20);
    for (int i = 0; i < 4; i++) send(20);
    exp_q.push_back(22); exp_q.push_back(24); exp_q.push_back(26);
    exp_q.push_back(28); exp_q.push_back(30);
    send(28); send(28); send(28); send(28); send(38);
    idle(2);
    chk("track_filt_dist", filt_dist, 30);
    chk("track_reject_cnt", reject_cnt, 0);
    chk("track_drained", exp_q.size(), 0);

    // Three step rejects flush and reload; re-converge to 40
    do_reset();
    exp_q.push_back(20);
    for (int i = 0; i < 4; i++) send(20);
    send(40); send(40); send(40);
    idle(2);
    chk("flush_reject_cnt", reject_cnt, 3);
    chk("flush_hold_filt", filt_dist, 20);
    chk("flush_drained", exp_q.size(), 0);
    exp_q.push_back(40);
    send(40); send(40); send(40);
    idle(2);
    chk("reconverge_filt", filt_dist, 40);
    // Accept between step rejects restarts the run: no flush here
    exp_q.push_back(41);
    send(60); send(60); send(45);
    exp_q.push_back(41);
    send(60); send(60); send(41);
    idle(2);
    chk("run_clear_reject_cnt", reject_cnt, 7);
    chk("run_clear_drained", exp_q.size(), 0);

    // Asynchronous reset from a busy state
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_filt_dist", filt_dist, 0);
    chk("rst2_reject_cnt", reject_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timeout: stale rises 99 cycles after the last accepted sample
    exp_q.push_back(50);
    for (int i = 0; i < 4; i++) send(50);
    repeat (98) @(posedge clk);
    #1;
    chk("stale_before_expiry", stale, 0);
    @(posedge clk);
    #1;
    chk("stale_at_expiry", stale, 1);
    chk("stale_hold_filt", filt_dist, 50);
    // Flushed history: 10s are not step-rejected against the old 50
    exp_q.push_back(10);
    for (int i = 0; i < 4; i++) send(10);
    chk("stale_cleared", stale, 0);
    chk("stale_reject_cnt", reject_cnt, 0);
    idle(2);
    chk("stale_drained", exp_q.size(), 0);

    // Reset mid-priming discards history
    do_reset();
    send(20); send(20);
    do_reset();
    exp_q.push_back(30);
    for (int i = 0; i < 4; i++) send(30);
    chk("midrst_filt_dist", filt_dist, 30);

    // Accepted sample exactly on the expiry cycle wins
    repeat (98) @(negedge clk);
    raw_dist  = 16'd30;
    raw_valid = 1'b1;
    exp_q.push_back(30);
    @(negedge clk);
    raw_valid = 1'b0;
    chk("expiry_tie_stale", stale, 0);
    @(posedge clk);
    #1;
    chk("expiry_tie_stale_after", stale, 0);

    idle(4);
    chk("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 Parameter: DEPTH, default 4; averaging window in samples; SHALL be a power of 2, range 2..16.
REQ-002 Parameter: MAX_CM, default 400; largest raw distance, in cm, treated as valid.
REQ-003 Parameter: STEP_LIMIT, default 10; largest accepted jump, in cm, from the current filt_dist once primed.
REQ-004 Parameter: TIMEOUT_CYC, default 24_000_000; clk cycles without an accepted sample before stale is raised (2 s at 12 MHz).
REQ-005 Port: clk  in  1  system clock, 12 MHz.
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: raw_dist  in  16  unfiltered distance in cm from the ultrasonic measurement stage; sampled only when raw_valid=1.
REQ-008 Port: raw_valid  in  1  single-cycle strobe in the clk domain, one per completed measurement.
REQ-009 Port: filt_dist  out  16  averaged distance in cm, consumed by movement control; holds its value between updates.
REQ-010 Port: filt_valid  out  1  single-cycle pulse on each filt_dist update.
REQ-011 Port: stale  out  1  level; no accepted sample within TIMEOUT_CYC.
REQ-012 Port: reject_cnt  out  8  count of rejected samples; saturates at 255.

Function
REQ-013 On a raw_valid cycle the sample SHALL be range-rejected if raw_dist==0 or raw_dist>MAX_CM.
REQ-014 Once primed, an in-range sample SHALL be step-rejected if |raw_dist - filt_dist| > STEP_LIMIT; a sample with a difference exactly equal to STEP_LIMIT SHALL be accepted.
REQ-015 Each reject SHALL increment reject_cnt by 1, saturating at 255; a rejected sample SHALL NOT change the buffer, the sum or filt_dist, and SHALL NOT pulse filt_valid.
REQ-016 The block SHALL count consecutive step-rejects; any accept or range-reject SHALL clear this count.
REQ-017 On the 3rd consecutive step-reject the block SHALL flush the buffer and load that sample as the first entry (fill=1, primed=0), so that real floor changes re-converge; this sample SHALL still be counted in reject_cnt.
REQ-018 Priming: accepted samples SHALL fill a DEPTH-entry circular buffer; primed SHALL become 1 when fill reaches DEPTH; no filt_valid SHALL be produced before primed.
REQ-019 The running sum SHALL be DEPTH-relative: sum_next = sum + new - oldest; sum width SHALL be 16+log2(DEPTH) bits so it never overflows.
REQ-020 filt_dist SHALL equal sum >> log2(DEPTH), truncated with no rounding.
REQ-021 Latency: for an accepted raw_valid in cycle N with primed true after the update, filt_dist SHALL update and filt_valid SHALL be 1 in cycle N+1.
REQ-022 The timeout counter SHALL reset on every accepted sample and SHALL otherwise count up.
REQ-023 When the timeout counter reaches TIMEOUT_CYC-1, the block SHALL set stale=1, flush the buffer (fill=0, sum=0, primed=0) and hold the counter; filt_dist SHALL keep its last value.
REQ-024 stale SHALL clear on the next filt_valid pulse.
REQ-025 If an accepted raw_valid coincides with timeout expiry, the sample SHALL take priority: no stale is raised and no flush occurs.

Reset
REQ-026 Reset SHALL set filt_dist=0, filt_valid=0, stale=0 and reject_cnt=0, and SHALL clear the buffer, sum, fill, the consecutive-reject count and the timeout counter.
REQ-027 Reset asserted mid-priming or mid-operation SHALL discard all history; the first output after release SHALL require DEPTH new accepted samples.

Structure
REQ-028 The default values of DEPTH, MAX_CM, STEP_LIMIT and TIMEOUT_CYC, and the reject threshold of 3, SHALL live in the shared elevator constants package.
REQ-029 The circular buffer plus running sum SHALL be one sub-module, dist_avg_buf, exposing push, flush, load-first, the sum and fill; the reject, stale and timeout control SHALL stay in distance_filter.

Verification (DEPTH=4, STEP_LIMIT=10, MAX_CM=400)
REQ-030 After reset, raw 20,20,24,24 -> no filt_valid on the first three samples; on the 4th, filt_valid with filt_dist=22.
REQ-031 Primed at 22, raw 60, then 0, then 401 -> all rejected, reject_cnt=3, filt_dist stays 22, no filt_valid.
REQ-032 Primed with 20 x4, then raw 28 -> filt_dist=22; then 28,28,28 -> outputs 24, 26, 28; raw 38 -> accepted (|38-28| equals the limit, not above it).
REQ-033 Primed at 20, then raw 40,40,40 -> three rejects and a flush on the 3rd; then 40,40,40 -> filt_valid with filt_dist=40 on the last.
REQ-034 With TIMEOUT_CYC=100, no raw_valid -> stale=1 at cycle 99 and the buffer is flushed; then 10 x4 -> filt_valid, filt_dist=10, stale=0.
REQ-035 rst_n pulsed low after 2 of 4 priming samples, then 4 samples of 30 -> exactly one filt_valid, on the 4th, with filt_dist=30; an accepted sample landing on the expiry cycle -> stale stays 0.
